// File: rtl/imm_alloc_pkg.sv
// Shared definitions for the immediate-file row allocator: row-count width
// and one-hot to binary index conversion.
package imm_alloc_pkg;

   localparam int MAX_ROWS = 64;
   localparam int MAX_RW   = 6;

   typedef logic [MAX_ROWS-1:0] row_vec_t;
   typedef logic [MAX_RW-1:0]   row_idx_t;

   // Width needed to hold a busy-row count from 0 up to and including nrow.
   function automatic int row_cnt_width(input int nrow);
      return $clog2(nrow) + 1;
   endfunction

   function automatic row_idx_t onehot_to_idx(input row_vec_t oh);
      row_idx_t idx;
      idx = '0;
      for (int i = 0; i < MAX_ROWS; i++) begin
         if (oh[i]) begin
            idx = idx | row_idx_t'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/imm_alloc_rrpick.sv
// Rotate-priority picker: first free row at or after ptr, wrapping modulo NROW.
module imm_alloc_rrpick
   import imm_alloc_pkg::*;
#(
   parameter int NROW = 8,
   parameter int RW   = 3
) (
   input  logic [NROW-1:0] busy,
   input  logic [RW-1:0]   ptr,
   output logic [NROW-1:0] onehot,
   output logic [RW-1:0]   idx,
   output logic            found
);

   row_vec_t oh_ext;

   always_comb begin
      onehot = '0;
      found  = 1'b0;
      for (int k = 0; k < NROW; k++) begin
         if (!found && !busy[(int'(ptr) + k) % NROW]) begin
            onehot[(int'(ptr) + k) % NROW] = 1'b1;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      oh_ext = '0;
      oh_ext[NROW-1:0] = onehot;
   end

   assign idx = RW'(onehot_to_idx(oh_ext));

endmodule

// File: rtl/imm_alloc.sv
// Immediate-file row allocator: grants one 4-entry row per request, round-robin.
// Optional IMM_ALLOC_ERR_EN adds a sticky o_err flag for illegal frees.
module imm_alloc
   import imm_alloc_pkg::*;
#(
   parameter int SIZE = 32,
   parameter int RW   = $clog2(SIZE/4)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_alloc_req,
   output logic              o_alloc_gnt,
   output logic              o_we,
   output logic [SIZE/4-1:0] o_waddr,
   output logic [RW-1:0]     o_row_idx,
   input  logic              i_free_vld,
   input  logic [RW-1:0]     i_free_idx,
   input  logic              i_flush,
   output logic              o_full,
   output logic [RW:0]       o_count
`ifdef IMM_ALLOC_ERR_EN
   ,
   output logic              o_err
`endif
);

   localparam int NROW = SIZE / 4;
   localparam int CW   = row_cnt_width(NROW);

   logic [NROW-1:0] busy_q;
   logic [NROW-1:0] busy_d;
   logic [RW-1:0]   ptr_q;
   logic [RW-1:0]   ptr_nxt;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic [NROW-1:0] cand_oh;
   logic [RW-1:0]   cand_idx;
   logic            cand_found;
   logic            full;
   logic            gnt;
   logic            free_hit;

   imm_alloc_rrpick #(
      .NROW (NROW),
      .RW   (RW)
   ) u_pick (
      .busy   (busy_q),
      .ptr    (ptr_q),
      .onehot (cand_oh),
      .idx    (cand_idx),
      .found  (cand_found)
   );

   assign full     = (count_q == CW'(NROW));
   assign free_hit = i_free_vld && (int'(i_free_idx) < NROW) && busy_q[i_free_idx];
   // Reset gates the grant so nothing is handed out while rows are being discarded.
   assign gnt      = i_rst_n && i_alloc_req && !full && !i_flush && cand_found;
   assign ptr_nxt  = (cand_idx == RW'(NROW - 1)) ? '0 : cand_idx + 1'b1;

   always_comb begin
      busy_d = busy_q;
      if (gnt) begin
         busy_d = busy_d | cand_oh;
      end
      if (free_hit) begin
         busy_d[i_free_idx] = 1'b0;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({gnt, free_hit})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_q  <= '0;
         ptr_q   <= '0;
         count_q <= '0;
      end else if (i_flush) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         if (gnt) begin
            ptr_q <= ptr_nxt;
         end
      end
   end

   assign o_alloc_gnt = gnt;
   assign o_we        = gnt;
   assign o_waddr     = gnt ? cand_oh : '0;
   assign o_row_idx   = gnt ? cand_idx : '0;
   assign o_full      = full;
   assign o_count     = (RW+1)'(count_q);

`ifdef IMM_ALLOC_ERR_EN
   logic err_q;
   logic illegal_free;

   assign illegal_free = i_free_vld && ((int'(i_free_idx) >= NROW) || !busy_q[i_free_idx]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_q <= 1'b0;
      end else if (i_flush) begin
         err_q <= 1'b0;
      end else if (illegal_free) begin
         err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`endif

endmodule
